red_pitaya_pwr_seq: RTL and testbench

// - Initiator side of the per-sub-module enable/reset/clock-enable handshake.
//   - Drives the enable_i line of N_MOD red_pitaya_rst_clken instances.
//   - Watches each instance's reset_n_o as an acknowledge.
// - Moves one module at a time from the current enable set to a register-written target set.
//   - Disables run highest index first; enables run lowest index first.
// - Reports busy, done and per-module timeout errors to the housekeeping registers.

---
 rtl/red_pitaya_pwr_seq_pkg.sv | 22 ++
 rtl/red_pitaya_pwr_seq_pick.sv | 34 +++
 rtl/red_pitaya_pwr_seq.sv | 123 ++++++++++++
 tb/tb_red_pitaya_pwr_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_pwr_seq_pkg.sv
// Shared types and elaboration helpers for the enable/reset/clock-enable power sequencer.
package red_pitaya_pwr_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StOnWait,
        StOffWait,
        StSettle
    } pwr_seq_state_t;

    // SETTLE_CYC must cover the 3-cycle rst_clken timer; TIMEOUT must outlast a settle window.
    function automatic bit pwr_seq_params_ok(int unsigned n_mod, int unsigned settle_cyc,
                                             int unsigned timeout);
        return (n_mod >= 1) && (n_mod <= 32) && (settle_cyc >= 4) && (timeout > settle_cyc);
    endfunction

    function automatic int unsigned pwr_seq_idx_w(int unsigned n_mod);
        return (n_mod > 1) ? $clog2(n_mod) : 1;
    endfunction

endpackage

// File: rtl/red_pitaya_pwr_seq_pick.sv
// Chooses the next sequencing action: highest module to disable, lowest module to enable.
module red_pitaya_pwr_seq_pick import red_pitaya_pwr_seq_pkg::*; #(
    parameter int unsigned N_MOD = 8,
    localparam int unsigned IDX_W = pwr_seq_idx_w(N_MOD)
) (
    input  logic [N_MOD-1:0] enable_i,
    input  logic [N_MOD-1:0] target_i,
    output logic             dis_valid_o,
    output logic [IDX_W-1:0] dis_idx_o,
    output logic             en_valid_o,
    output logic [IDX_W-1:0] en_idx_o
);

    logic [N_MOD-1:0] dis_vec;
    logic [N_MOD-1:0] en_vec;

    assign dis_vec = enable_i & ~target_i;
    assign en_vec  = target_i & ~enable_i;

    always_comb begin
        dis_valid_o = |dis_vec;
        en_valid_o  = |en_vec;
        dis_idx_o   = '0;
        en_idx_o    = '0;
        // Ascending scan keeps the last hit (highest); descending scan keeps the lowest.
        for (int i = 0; i < int'(N_MOD); i++) begin
            if (dis_vec[i]) dis_idx_o = IDX_W'(i);
        end
        for (int i = int'(N_MOD) - 1; i >= 0; i--) begin
            if (en_vec[i]) en_idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/red_pitaya_pwr_seq.sv
// Steps rst_clken enables one module at a time toward a register-written target set.
module red_pitaya_pwr_seq import red_pitaya_pwr_seq_pkg::*; #(
    parameter int unsigned N_MOD      = 8,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned TIMEOUT    = 64,
    localparam int unsigned IDX_W     = pwr_seq_idx_w(N_MOD)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_MOD-1:0] req_mask_i,
    input  logic             req_we_i,
    input  logic             err_clr_i,
    input  logic [N_MOD-1:0] ack_i,
    output logic [N_MOD-1:0] enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [N_MOD-1:0] err_o,
    output logic [IDX_W-1:0] cur_idx_o
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);

    if (!pwr_seq_params_ok(N_MOD, SETTLE_CYC, TIMEOUT)) begin : g_param_err
        $error("red_pitaya_pwr_seq: illegal N_MOD/SETTLE_CYC/TIMEOUT combination");
    end

    pwr_seq_state_t     state_q;
    logic [N_MOD-1:0]   target_q;
    logic [N_MOD-1:0]   enable_q;
    logic [N_MOD-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   cur_idx_q;
    logic [TIMER_W-1:0] timer_q;
    logic               done_q;

    logic               dis_valid, en_valid;
    logic [IDX_W-1:0]   dis_idx, en_idx;
    logic               ack_cur, in_wait, ack_match, timeout_hit;
    logic [TIMER_W-1:0] timer_inc;
    logic [N_MOD-1:0]   err_set;

    red_pitaya_pwr_seq_pick #(
        .N_MOD (N_MOD)
    ) u_pick (
        .enable_i    (enable_q),
        .target_i    (target_q),
        .dis_valid_o (dis_valid),
        .dis_idx_o   (dis_idx),
        .en_valid_o  (en_valid),
        .en_idx_o    (en_idx)
    );

    always_comb begin
        ack_cur     = ack_i[cur_idx_q];
        in_wait     = (state_q == StOnWait) || (state_q == StOffWait);
        ack_match   = (state_q == StOnWait) ? ack_cur : !ack_cur;
        timeout_hit = in_wait && !ack_match && (timer_q == TIMER_LAST);
        timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        err_set     = '0;
        if (timeout_hit) err_set[cur_idx_q] = 1'b1;
        // A timeout set on the same cycle as a clear survives.
        err_d = (err_clr_i ? '0 : err_q) | err_set;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            target_q  <= '0;
            enable_q  <= '0;
            err_q     <= '0;
            cur_idx_q <= '0;
            timer_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err_d;
            if (req_we_i) target_q <= req_mask_i;
            unique case (state_q)
                StIdle: begin
                    if (target_q != enable_q) state_q <= StScan;
                end
                StScan: begin
                    timer_q <= '0;
                    if (dis_valid) begin
                        enable_q[dis_idx] <= 1'b0;
                        cur_idx_q         <= dis_idx;
                        state_q           <= StOffWait;
                    end else if (en_valid) begin
                        enable_q[en_idx] <= 1'b1;
                        cur_idx_q        <= en_idx;
                        state_q          <= StOnWait;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StOnWait, StOffWait: begin
                    // On timeout the enable stays where it was driven; only the error flags it.
                    if (ack_match || timeout_hit) begin
                        state_q <= StSettle;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                StSettle: begin
                    if (timer_q == SETTLE_LAST) state_q <= StScan;
                    else                        timer_q <= timer_inc;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign enable_o  = enable_q;
    assign busy_o    = (state_q != StIdle) || (target_q != enable_q);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign cur_idx_o = cur_idx_q;

endmodule

// File: tb/tb_red_pitaya_pwr_seq.sv
// Bench for red_pitaya_pwr_seq: timeline model of the sequencing rules plus directed scenarios.
module tb_red_pitaya_pwr_seq;

    localparam int N          = 4;
    localparam int SETTLE_CYC = 8;
    localparam int TIMEOUT    = 64;

    localparam int PH_IDLE   = 0;
    localparam int PH_PICK   = 1;
    localparam int PH_ON     = 2;
    localparam int PH_OFF    = 3;
    localparam int PH_SETTLE = 4;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] tgt;
        logic [3:0] err;
        int         idx;
        int         phase;
        int         left;
        logic       done;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] req_mask_i = '0;
    logic       req_we_i = 1'b0;
    logic       err_clr_i = 1'b0;
    logic [3:0] ack_i;
    logic [3:0] enable_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] err_o;
    logic [1:0] cur_idx_o;

    red_pitaya_pwr_seq #(
        .N_MOD      (N),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_mask_i (req_mask_i),
        .req_we_i   (req_we_i),
        .err_clr_i  (err_clr_i),
        .ack_i      (ack_i),
        .enable_o   (enable_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .cur_idx_o  (cur_idx_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // rst_clken stand-in: each ack follows its enable after dly cycles, or is held low if stuck.
    logic [3:0][7:0] hist;
    int unsigned     dly [4] = '{3, 3, 3, 3};
    logic [3:0]      stuck = '0;

    always @(posedge clk) begin
        if (!rstn) hist <= '0;
        else for (int i = 0; i < 4; i++) hist[i] <= {hist[i][6:0], enable_o[i]};
    end

    always_comb begin
        ack_i = '0;
        for (int i = 0; i < 4; i++) begin
            if (!stuck[i]) ack_i[i] = hist[i][dly[i] - 1];
        end
    end

    // One edge of the sequencing timeline, from the rules: pick, wait for ack or timeout, settle.
    function automatic mdl_t mdl_next(mdl_t m, logic we, logic [3:0] mask, logic clr,
                                      logic [3:0] ack);
        mdl_t n;
        int   k;
        n      = m;
        n.done = 1'b0;
        if (we)  n.tgt = mask;
        if (clr) n.err = '0;
        case (m.phase)
            PH_IDLE: if (m.tgt != m.en) n.phase = PH_PICK;
            PH_PICK: begin
                k = -1;
                for (int i = 0; i < 4; i++) if (m.en[i] && !m.tgt[i]) k = i;
                if (k >= 0) begin
                    n.en[k] = 1'b0; n.idx = k; n.phase = PH_OFF; n.left = TIMEOUT;
                end else begin
                    for (int i = 3; i >= 0; i--) if (m.tgt[i] && !m.en[i]) k = i;
                    if (k >= 0) begin
                        n.en[k] = 1'b1; n.idx = k; n.phase = PH_ON; n.left = TIMEOUT;
                    end else begin
                        n.done = 1'b1; n.phase = PH_IDLE;
                    end
                end
            end
            PH_ON, PH_OFF: begin
                if (ack[m.idx] == (m.phase == PH_ON)) begin
                    n.phase = PH_SETTLE; n.left = SETTLE_CYC;
                end else if (m.left == 1) begin
                    n.err[m.idx] = 1'b1; n.phase = PH_SETTLE; n.left = SETTLE_CYC;
                end else begin
                    n.left = m.left - 1;
                end
            end
            PH_SETTLE: begin
                if (m.left == 1) n.phase = PH_PICK;
                else             n.left = m.left - 1;
            end
            default: ;
        endcase
        return n;
    endfunction

    mdl_t m;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= mdl_next(m, req_we_i, req_mask_i, err_clr_i, ack_i);
    end

    int n_tests = 0;
    int n_fail  = 0;

    int         ev_q[$];
    int         evc_q[$];
    int         idx_q[$];
    int         done_cnt;
    int         ack0_rise;
    int         err_rise;
    logic [3:0] prev_en;
    logic [3:0] prev_err;
    logic       prev_ack0;
    logic [3:0] tgt_shadow = '0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_cycle();
        logic exp_busy;
        exp_busy = (m.phase != PH_IDLE) || (m.tgt != m.en);
        n_tests++;
        if (enable_o !== m.en || err_o !== m.err || done_o !== m.done || busy_o !== exp_busy ||
            cur_idx_o !== 2'(m.idx)) begin
            n_fail++;
            $display("FAIL model cyc=%0d: en %b exp %b, err %b exp %b, done %b exp %b, busy %b exp %b, idx %0d exp %0d",
                     cyc, enable_o, m.en, err_o, m.err, done_o, m.done, busy_o, exp_busy,
                     cur_idx_o, m.idx);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rstn) check_cycle();
        for (int i = 0; i < 4; i++) begin
            if (enable_o[i] != prev_en[i]) begin
                ev_q.push_back(i * 2 + int'(enable_o[i]));
                evc_q.push_back(cyc);
                idx_q.push_back(int'(cur_idx_o));
            end
        end
        prev_en = enable_o;
        if (done_o) done_cnt++;
        if (ack_i[0] && !prev_ack0) ack0_rise = cyc;
        prev_ack0 = ack_i[0];
        if (err_o != 0 && prev_err == 0) err_rise = cyc;
        prev_err = err_o;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        ev_q.delete(); evc_q.delete(); idx_q.delete();
        done_cnt = 0; ack0_rise = -1; err_rise = -1;
        prev_en = enable_o; prev_err = err_o; prev_ack0 = ack_i[0];
    endtask

    task automatic write_req(logic [3:0] mask);
        req_mask_i = mask;
        req_we_i   = 1'b1;
        tgt_shadow = mask;
        step();
        req_we_i   = 1'b0;
    endtask

    task automatic wait_done(string name, int max);
        int n = 0;
        do begin
            step();
            n++;
        end while (!done_o && n < max);
        check({name, "_done"}, 32'(done_o), 1);
    endtask

    function automatic int ev_at(int i);
        return (i < ev_q.size()) ? ev_q[i] : -1;
    endfunction

    function automatic int find_ev(int code);
        for (int i = 0; i < ev_q.size(); i++) if (ev_q[i] == code) return i;
        return -1;
    endfunction

    initial begin
        int n;
        int i2;
        logic early_low;

        clear_log();
        run(3);
        rstn = 1'b1;
        check("rst_enable", 32'(enable_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_idx", 32'(cur_idx_o), 0);
        run(3);

        // 1: enable 0101 from empty
        clear_log();
        write_req(4'b0101);
        wait_done("t1", 500);
        run(4);
        check("t1_ev_count", 32'(ev_q.size()), 2);
        check("t1_ev0_bit0_on", 32'(ev_at(0)), 1);
        check("t1_ev1_bit2_on", 32'(ev_at(1)), 5);
        i2 = find_ev(5);
        check("t1_settle_gap_ok",
              32'(i2 >= 0 && ack0_rise >= 0 && (evc_q[i2] - ack0_rise) >= SETTLE_CYC), 1);
        check("t1_one_done", 32'(done_cnt), 1);
        check("t1_err", 32'(err_o), 0);
        check("t1_final", 32'(enable_o), 4'b0101);

        // 2: 1111 -> 0000, highest first
        write_req(4'b1111);
        wait_done("t2_setup", 500);
        clear_log();
        write_req(4'b0000);
        early_low = 1'b0;
        n = 0;
        while (!done_o && n < 2000) begin
            if (!busy_o) early_low = 1'b1;
            step();
            n++;
        end
        check("t2_done", 32'(done_o), 1);
        check("t2_busy_held", 32'(early_low), 0);
        check("t2_ev_count", 32'(ev_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_fall_order", 32'(ev_at(i)), 32'((3 - i) * 2));
            check("t2_idx_order", 32'((i < idx_q.size()) ? idx_q[i] : -1), 32'(3 - i));
        end

        // 3: 0110 -> 1001, disables first
        write_req(4'b0110);
        wait_done("t3_setup", 500);
        clear_log();
        write_req(4'b1001);
        wait_done("t3", 1000);
        check("t3_ev0", 32'(ev_at(0)), 4);
        check("t3_ev1", 32'(ev_at(1)), 2);
        check("t3_ev2", 32'(ev_at(2)), 1);
        check("t3_ev3", 32'(ev_at(3)), 7);
        check("t3_final", 32'(enable_o), 4'b1001);

        // 4: ack of bit 1 stuck low
        clear_log();
        stuck = 4'b0010;
        write_req(4'b0010);
        wait_done("t4", 2000);
        i2 = find_ev(3);
        check("t4_err", 32'(err_o), 4'b0010);
        check("t4_err_latency", 32'((i2 >= 0) ? (err_rise - evc_q[i2]) : -1), TIMEOUT);
        check("t4_enable_kept", 32'(enable_o), 4'b0010);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        check("t4_err_cleared", 32'(err_o), 0);
        stuck = '0;
        write_req(4'b0000);
        wait_done("t4_cleanup", 500);

        // 5: retarget during ON_WAIT of bit 0
        clear_log();
        write_req(4'b0011);
        n = 0;
        while (!enable_o[0] && n < 50) begin
            step();
            n++;
        end
        check("t5_bit0_on", 32'(enable_o[0]), 1);
        write_req(4'b0000);
        wait_done("t5", 500);
        check("t5_ev0", 32'(ev_at(0)), 1);
        check("t5_ev1", 32'(ev_at(1)), 0);
        check("t5_bit1_never", 32'(find_ev(3)), 32'(-1));
        check("t5_final", 32'(enable_o), 0);

        // 6: async reset while settling
        write_req(4'b1111);
        n = 0;
        while (!ack_i[0] && n < 50) begin
            step();
            n++;
        end
        run(2);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_async_enable", 32'(enable_o), 0);
        check("t6_async_err", 32'(err_o), 0);
        check("t6_async_busy", 32'(busy_o), 0);
        run(3);
        rstn = 1'b1;
        tgt_shadow = '0;
        check("t6_rel_enable", 32'(enable_o), 0);
        check("t6_rel_idx", 32'(cur_idx_o), 0);
        clear_log();
        write_req(4'b0011);
        wait_done("t6_restart", 500);
        check("t6_restart_final", 32'(enable_o), 4'b0011);
        write_req(4'b0000);
        wait_done("t6_cleanup", 500);

        // Random: masks, write timing, ack delays, stuck acks and clears
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) dly[i] = $urandom_range(1, 4);
            stuck = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            write_req(4'($urandom_range(0, 15)));
            n = $urandom_range(0, 150);
            for (int c = 0; c < n; c++) begin
                err_clr_i = ($urandom_range(0, 11) == 0);
                req_we_i  = ($urandom_range(0, 39) == 0);
                if (req_we_i) begin
                    req_mask_i = 4'($urandom_range(0, 15));
                    tgt_shadow = req_mask_i;
                end
                step();
            end
            err_clr_i = 1'b0;
            req_we_i  = 1'b0;
        end
        stuck = '0;
        n = 0;
        do begin
            step();
            n++;
        end while (busy_o && n < 3000);
        check("rand_idle", 32'(busy_o), 0);
        check("rand_final_en", 32'(enable_o), 32'(tgt_shadow));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
